// File: rtl/uart_rom_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : uart_rom_loader_pkg                                    |
// | Shared constants and state encodings for the UART ROM loader.    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package uart_rom_loader_pkg;

    // 25.125 MHz system clock / 115200 baud
    localparam int         DEFAULT_CLKS_PER_BIT = 218;
    localparam logic [7:0] DEFAULT_SYNC_BYTE    = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CNT_HI   = 4'd1,
        ST_CNT_LO   = 4'd2,
        ST_WORD_HI  = 4'd3,
        ST_WORD_LO  = 4'd4,
        ST_STROBE   = 4'd5,
        ST_WAIT_ACK = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // States in which the FSM drains the holding register; while a word is
    // being strobed/acknowledged the received byte must stay buffered.
    function automatic logic accepts_byte(input loader_state_t s);
        return (s != ST_STROBE) && (s != ST_WAIT_ACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rom_loader_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_byte                                           |
// | 8N1 UART receiver: 2-flop synchronizer, bit timer, one-cycle     |
// | byte_valid / frame_err pulses.                                   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module uart_rx_byte
    import uart_rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int             TW      = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  C_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  C_FULL  = TW'(CLKS_PER_BIT - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    rx_state_t     r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          w_fall;

    assign w_fall = r_prev & ~r_sync2;

    // Metastability synchronizer plus one extra stage for edge detection; idle line is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Bit timer and shifter: mid-bit sampling, LSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RX_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_timer <= '0;
                    if (w_fall) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_timer == C_HALF) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        // A start bit that is high again by mid-bit was a glitch
                        r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_timer == C_FULL) begin
                        r_timer <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_timer == C_FULL) begin
                        r_timer <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= r_shift;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rom_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rom_loader                                        |
// | Receives a framed Hack program over UART and writes it into the  |
// | SoC program ROM via the load/sck/data/ack handshake.             |
// | Frame: SYNC, N hi, N lo, then N words (hi byte, lo byte).        |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int         DATA_WIDTH   = 16,
    parameter int         COUNT_WIDTH  = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   uart_rx,
    output logic                   rom_loader_load,
    output logic                   rom_loader_sck,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_ack,
    output logic                   done_loading,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    logic                   w_byte_valid;
    logic [7:0]             w_byte_data;
    logic                   w_frame_err;

    logic                   r_hold_full;
    logic [7:0]             r_hold_byte;
    loader_state_t          r_state;
    logic [7:0]             r_cnt_hi;
    logic [7:0]             r_data_hi;
    logic [COUNT_WIDTH-1:0] r_count_n;

    logic                   w_consume;
    logic                   w_overrun;
    logic                   w_frame_abort;
    logic                   w_is_sync;
    logic [COUNT_WIDTH-1:0] w_count_full;
    logic [COUNT_WIDTH-1:0] w_words_next;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    assign w_consume     = r_hold_full && accepts_byte(r_state);
    // Only a byte that finds the buffer full and not draining is lost
    assign w_overrun     = w_byte_valid && r_hold_full && !w_consume;
    assign w_frame_abort = w_frame_err && (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_is_sync     = (r_hold_byte == SYNC_BYTE);
    assign w_count_full  = COUNT_WIDTH'({r_cnt_hi, r_hold_byte});
    assign w_words_next  = words_loaded + COUNT_WIDTH'(1);

    // One-byte holding register between the receiver and the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_hold_byte <= '0;
        end else begin
            if (w_byte_valid && (!r_hold_full || w_consume)) begin
                r_hold_full <= 1'b1;
                r_hold_byte <= w_byte_data;
            end else if (w_consume) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Session FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_cnt_hi        <= '0;
            r_data_hi       <= '0;
            r_count_n       <= '0;
            rom_loader_load <= 1'b0;
            rom_loader_sck  <= 1'b0;
            rom_loader_data <= '0;
            done_loading    <= 1'b0;
            error           <= 1'b0;
            words_loaded    <= '0;
        end else begin
            rom_loader_sck <= 1'b0;
            if (w_frame_abort || w_overrun) begin
                r_state         <= ST_ERR;
                rom_loader_load <= 1'b0;
                error           <= 1'b1;
                done_loading    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        // Anything but the sync marker is discarded here
                        if (w_consume && w_is_sync) begin
                            r_state         <= ST_CNT_HI;
                            words_loaded    <= '0;
                            done_loading    <= 1'b0;
                            error           <= 1'b0;
                            rom_loader_load <= 1'b1;
                        end
                    end
                    ST_CNT_HI: begin
                        if (w_consume) begin
                            r_cnt_hi <= r_hold_byte;
                            r_state  <= ST_CNT_LO;
                        end
                    end
                    ST_CNT_LO: begin
                        if (w_consume) begin
                            r_count_n <= w_count_full;
                            if (w_count_full == '0) begin
                                r_state         <= ST_DONE;
                                rom_loader_load <= 1'b0;
                                done_loading    <= 1'b1;
                            end else begin
                                r_state <= ST_WORD_HI;
                            end
                        end
                    end
                    ST_WORD_HI: begin
                        if (w_consume) begin
                            r_data_hi <= r_hold_byte;
                            r_state   <= ST_WORD_LO;
                        end
                    end
                    ST_WORD_LO: begin
                        if (w_consume) begin
                            rom_loader_data <= DATA_WIDTH'({r_data_hi, r_hold_byte});
                            rom_loader_sck  <= 1'b1;
                            r_state         <= ST_STROBE;
                        end
                    end
                    ST_STROBE: begin
                        r_state <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (rom_loader_ack) begin
                            words_loaded <= w_words_next;
                            if (w_words_next == r_count_n) begin
                                r_state         <= ST_DONE;
                                rom_loader_load <= 1'b0;
                                done_loading    <= 1'b1;
                            end else begin
                                r_state <= ST_WORD_HI;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
